// File: rtl/mips_defs.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM states
// and the datapath select encodings.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MUL_WAIT,
        ST_MEM,
        ST_WB
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Load/store width lives in the low two opcode bits (11 word, 01 half, 00 byte).
    function automatic logic [1:0] size_from_op(input logic [1:0] low);
        case (low)
            2'b11:   size_from_op = SIZE_WORD;
            2'b01:   size_from_op = SIZE_HALF;
            default: size_from_op = SIZE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode classifier: one-hot instruction class plus the memory
// access width for loads and stores.
module mc_opclass
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    output logic       is_r,
    output logic       is_mul,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_br,
    output logic       is_j,
    output logic       is_addi,
    output logic       illegal,
    output logic [1:0] size
);

    always_comb begin
        is_r    = 1'b0;
        is_mul  = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_br   = 1'b0;
        is_j    = 1'b0;
        is_addi = 1'b0;
        illegal = 1'b0;
        size    = size_from_op(opcode[1:0]);
        case (opcode)
            OP_RTYPE:            is_r    = 1'b1;
            OP_ADDI:             is_addi = 1'b1;
            OP_BEQ, OP_BNE:      is_br   = 1'b1;
            OP_MUL:              is_mul  = 1'b1;
            OP_J:                is_j    = 1'b1;
            OP_LB, OP_LH, OP_LW: is_ld   = 1'b1;
            OP_SB, OP_SH, OP_SW: is_st   = 1'b1;
            default:             illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, multiply
// wait, memory and write-back with a memory-timeout watchdog.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       mul_done,
    input  logic       zero,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_size,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mul_start,
    output logic       illegal_op,
    output logic       bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             waiting;
    logic             timeout;
    logic             is_r, is_mul, is_ld, is_st, is_br, is_j, is_addi, illegal;
    logic [1:0]       size;
    logic             br_taken;

    mc_opclass u_opclass (
        .opcode  (opcode),
        .is_r    (is_r),
        .is_mul  (is_mul),
        .is_ld   (is_ld),
        .is_st   (is_st),
        .is_br   (is_br),
        .is_j    (is_j),
        .is_addi (is_addi),
        .illegal (illegal),
        .size    (size)
    );

    // mem_ready in the expiry cycle beats the timeout.
    assign waiting  = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
    assign timeout  = (MEM_TIMEOUT != 0) && waiting && (cnt == CNT_LAST);
    assign br_taken = (opcode == OP_BNE) ? !zero : zero;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_next;
    end

    // Any state change (and a FETCH-to-FETCH timeout retry) restarts the watchdog.
    always_ff @(posedge clk) begin
        if (rst)                                cnt <= '0;
        else if (state_next != state || timeout) cnt <= '0;
        else if (waiting)                       cnt <= cnt + CNT_W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_r || is_addi || is_br || is_ld || is_st) state_next = ST_EXEC;
                else if (is_mul)                                state_next = ST_MUL_WAIT;
                else                                            state_next = ST_FETCH;
            end
            ST_EXEC: begin
                if (is_br)               state_next = ST_FETCH;
                else if (is_ld || is_st) state_next = ST_MEM;
                else                     state_next = ST_WB;
            end
            ST_MUL_WAIT: if (mul_done) state_next = ST_WB;
            ST_MEM: begin
                if (mem_ready)    state_next = is_ld ? ST_WB : ST_FETCH;
                else if (timeout) state_next = ST_FETCH;
            end
            ST_WB:       state_next = ST_FETCH;
            default:     state_next = ST_FETCH;
        endcase
    end

    // Outputs are forced low while rst is high so a reset mid-instruction
    // cannot leak a write or strobe.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = SIZE_WORD;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALUOP_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mul_start  = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_read  = !timeout;
                    alu_src_b = SRCB_FOUR;
                    bus_err   = timeout;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH2;
                    mul_start  = is_mul;
                    illegal_op = illegal;
                    if (is_j) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                    end
                end
                ST_EXEC: begin
                    alu_src_a = 1'b1;
                    if (is_r) begin
                        alu_op = ALUOP_FUNCT;
                    end else if (is_br) begin
                        alu_op   = ALUOP_SUB;
                        pc_write = br_taken;
                        pc_src   = PC_SRC_ALUOUT;
                    end else if (is_addi || is_ld || is_st) begin
                        alu_src_b = SRCB_IMM;
                    end
                end
                ST_MEM: begin
                    iord      = 1'b1;
                    mem_size  = size;
                    mem_read  = is_ld && !timeout;
                    mem_write = is_st && !timeout;
                    bus_err   = timeout;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_r || is_mul;
                    mem_to_reg = is_ld;
                end
                default: ;
            endcase
        end
    end

endmodule
